// File: rtl/io_mux_arbiter.sv
// Round-robin pad-ownership arbiter for shared IO: receive functions hand over directly,
// transmit grants end with a turnaround gap. Optional grant timeout: IO_MUX_ARBITER_TIMEOUT_EN.
//
//   state      | meaning
//   IDLE       | no owner, pad parked on receive function 0
//   GRANT      | one function owns the pad until it drops req (or times out)
//   TURNAROUND | pad undriven for TURNAROUND cycles after a transmit grant
module io_mux_arbiter #(
    parameter int TXCOUNT    = 2,
    parameter int RXCOUNT    = 2,
    parameter int TURNAROUND = 2,
    parameter int TIMEOUT    = 16,
    localparam int FUNCCOUNT = TXCOUNT + RXCOUNT,
    localparam int MUXWIDTH  = $clog2(FUNCCOUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FUNCCOUNT-1:0] req,
    output logic [FUNCCOUNT-1:0] grant,
    output logic [MUXWIDTH-1:0]  func_select,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURNAROUND = 2'd2;

    localparam int TA_W = $clog2(TURNAROUND + 1);

    if (TXCOUNT <= 0 || RXCOUNT <= 0 || TURNAROUND < 1 || TIMEOUT < 2) begin : g_bad_params
        $error("io_mux_arbiter: TXCOUNT, RXCOUNT must be > 0, TURNAROUND >= 1, TIMEOUT >= 2");
    end

    logic [1:0]           state_q, state_d;
    logic [FUNCCOUNT-1:0] grant_q, grant_d;
    logic [MUXWIDTH-1:0]  sel_q, sel_d;
    logic [MUXWIDTH-1:0]  last_q, last_d;
    logic [TA_W-1:0]      ta_q, ta_d;
    logic                 busy_q;
    logic                 to_expired;

    logic                 win_found;
    logic [MUXWIDTH-1:0]  win_idx;
    logic [MUXWIDTH:0]    cand;
    logic                 rearb;

`ifdef IO_MUX_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);
    logic [TO_W-1:0] to_q, to_d;

    assign to_expired = (to_q == '0);
`else
    assign to_expired = 1'b0;
`endif

    // Search starts one past the previous winner and wraps, so the previous winner is tried last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= FUNCCOUNT; off++) begin
            cand = {1'b0, last_q} + (MUXWIDTH+1)'(off);
            if (cand >= (MUXWIDTH+1)'(FUNCCOUNT)) begin
                cand = cand - (MUXWIDTH+1)'(FUNCCOUNT);
            end
            if (!win_found && req[cand[MUXWIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[MUXWIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        ta_d    = ta_q;
        rearb   = 1'b0;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            S_IDLE: rearb = 1'b1;
            S_GRANT: begin
                if (!req[sel_q] || to_expired) begin
                    if (sel_q >= MUXWIDTH'(RXCOUNT)) begin
                        state_d = S_TURNAROUND;
                        grant_d = '0;
                        sel_d   = '0;
                        ta_d    = TA_W'(TURNAROUND - 1);
                    end else begin
                        rearb = 1'b1;
                    end
                end else begin
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
                    to_d = to_q - TO_W'(1);
`endif
                end
            end
            S_TURNAROUND: begin
                if (ta_q == '0) begin
                    rearb = 1'b1;
                end else begin
                    ta_d = ta_q - TA_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase

        if (rearb) begin
            if (win_found) begin
                state_d          = S_GRANT;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                sel_d            = win_idx;
                last_d           = win_idx;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
                to_d             = TO_W'(TIMEOUT - 1);
`endif
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= MUXWIDTH'(FUNCCOUNT - 1);
            ta_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ta_q    <= ta_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

`ifdef IO_MUX_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    assign grant       = grant_q;
    assign func_select = sel_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_io_mux_arbiter.sv
// Self-checking bench for io_mux_arbiter: directed scenarios with literal expectations plus
// randomized requests/resets compared every cycle against an ownership-level model.
module tb_io_mux_arbiter;

    localparam int TX = 2;
    localparam int RX = 2;
    localparam int TA = 2;
    localparam int TO = 4;
    localparam int F  = TX + RX;
    localparam int MW = $clog2(F);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [F-1:0]  req = '0;
    logic [F-1:0]  grant;
    logic [MW-1:0] func_select;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: who owns the pad (-1 = nobody), idle cycles still owed, previous winner, cycles held.
    int m_owner = -1;
    int m_quiet = 0;
    int m_last  = F - 1;
    int m_held  = 0;

    always #5 clk = ~clk;

    io_mux_arbiter #(
        .TXCOUNT   (TX),
        .RXCOUNT   (RX),
        .TURNAROUND(TA),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .func_select(func_select),
        .busy       (busy)
    );

    function automatic logic [F-1:0] m_grant();
        logic [F-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [MW-1:0] m_sel();
        return (m_owner >= 0) ? MW'(m_owner) : '0;
    endfunction

    function automatic logic m_busy();
        return (m_owner >= 0) || (m_quiet > 0);
    endfunction

    task automatic m_arbitrate();
        int i;
        m_owner = -1;
        for (int k = 1; k <= F; k++) begin
            i = (m_last + k) % F;
            if (req[i]) begin
                m_owner = i;
                m_last  = i;
                m_held  = 1;
                break;
            end
        end
    endtask

    task automatic m_step();
        bit revoke;
        revoke = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_quiet = 0;
            m_last  = F - 1;
            m_held  = 0;
        end else if (m_owner >= 0) begin
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
            revoke = (m_held >= TO);
`endif
            if (!req[m_owner] || revoke) begin
                if (m_owner >= RX) begin
                    m_owner = -1;
                    m_quiet = TA;
                end else begin
                    m_arbitrate();
                end
            end else begin
                m_held++;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
            if (m_quiet == 0) m_arbitrate();
        end else begin
            m_arbitrate();
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic check(input string name, input logic [F-1:0] eg, input logic [MW-1:0] es,
                         input logic eb);
        n_checks++;
        if (grant === eg && func_select === es && busy === eb) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
                     name, $time, grant, func_select, busy, eg, es, eb);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("model", m_grant(), m_sel(), m_busy());
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        repeat (3) cyc();
        chk_en = 1'b1;
        check("reset", 4'b0000, 2'd0, 1'b0);

        // Single receive request: 1-cycle latency, released back to idle.
        rst_n = 1'b1;
        req   = 4'b0001;
        cyc();
        check("rx0_grant", 4'b0001, 2'd0, 1'b1);
        repeat (3) cyc();
        req = 4'b0000;
        cyc();
        check("rx0_release_idle", 4'b0000, 2'd0, 1'b0);

        // Two transmitters: turnaround gap between them.
        req = 4'b1100;
        cyc();
        check("tx2_grant", 4'b0100, 2'd2, 1'b1);
        cyc();
        check("tx2_no_preempt", 4'b0100, 2'd2, 1'b1);
        req = 4'b1000;
        cyc();
        check("ta_cycle1", 4'b0000, 2'd0, 1'b1);
        cyc();
        check("ta_cycle2", 4'b0000, 2'd0, 1'b1);
        cyc();
        check("tx3_after_ta", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        cyc();
        check("tx3_release_ta", 4'b0000, 2'd0, 1'b1);
        cyc();
        cyc();
        check("ta_to_idle", 4'b0000, 2'd0, 1'b0);

        // Receive handover with no idle gap.
        req = 4'b0011;
        cyc();
        check("rr_rx0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0010;
        cyc();
        check("rr_rx1_direct", 4'b0010, 2'd1, 1'b1);
        req = 4'b0001;
        cyc();
        check("rr_rx0_again", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        cyc();
        check("rr_idle", 4'b0000, 2'd0, 1'b0);

        // Reset during turnaround aborts it.
        req = 4'b0100;
        cyc();
        check("tx2_before_rst", 4'b0100, 2'd2, 1'b1);
        req = 4'b0010;
        cyc();
        check("ta_before_rst", 4'b0000, 2'd0, 1'b1);
        rst_n = 1'b0;
        cyc();
        check("rst_in_ta", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc();
        check("after_rst_grant", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        cyc();
        check("after_rst_idle", 4'b0000, 2'd0, 1'b0);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
`ifdef IO_MUX_ARBITER_TIMEOUT_EN
        req = 4'b1001;
        cyc();
        check("to_rx0_c1", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("to_rx0_hold", 4'b0001, 2'd0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("to_tx3_hold", 4'b1000, 2'd3, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("to_ta", 4'b0000, 2'd0, 1'b1);
        end
        cyc();
        check("to_rx0_again", 4'b0001, 2'd0, 1'b1);
`else
        req = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            cyc();
            check("unbounded_hold", 4'b0001, 2'd0, 1'b1);
        end
`endif
        req = 4'b0000;
        repeat (4) cyc();

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int b = 0; b < F; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            cyc();
        end

        rst_n = 1'b1;
        req   = '0;
        repeat (6) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_mux_arbiter.md
IO_MUX_ARBITER -- requirements
Module: io_mux_arbiter

Interface
REQ-001 The module SHALL have parameter TXCOUNT, default 2, the number of transmit functions; must be > 0.
REQ-002 The module SHALL have parameter RXCOUNT, default 2, the number of receive functions; must be > 0.
REQ-003 The module SHALL have parameter TURNAROUND, default 2, the number of idle cycles after any transmit grant ends; must be >= 1.
REQ-004 The module SHALL have parameter TIMEOUT, default 16, the maximum grant length in cycles; it is used only with IO_MUX_ARBITER_TIMEOUT_EN and must be >= 2.
REQ-005 The module SHALL define localparam FUNCCOUNT = TXCOUNT+RXCOUNT and localparam MUXWIDTH = $clog2(FUNCCOUNT).
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 The module SHALL have port req, input, FUNCCOUNT bits: per-function pad request; bit i is function index i, and receive functions are the low RXCOUNT bits.
REQ-009 The module SHALL have port grant, output, FUNCCOUNT bits: one-hot-or-zero pad ownership.
REQ-010 The module SHALL have port func_select, output, MUXWIDTH bits: function index that drives the pad function mux.
REQ-011 The module SHALL have port busy, output, 1 bit: high in GRANT or TURNAROUND.
REQ-012 The module SHALL make elaboration fail when TXCOUNT <= 0, RXCOUNT <= 0 or TURNAROUND < 1.

Function
REQ-013 The module SHALL implement the states IDLE, GRANT and TURNAROUND; all outputs are registered.
REQ-014 In IDLE, the module SHALL hold grant = 0 and func_select = 0 (parked on receive function 0, pad undriven).
REQ-015 In IDLE with req != 0, the module SHALL pick the winner round-robin and enter GRANT on the next edge, with grant and func_select valid in that same cycle (latency 1 cycle from req to grant).
REQ-016 Round-robin search SHALL start at index (last_winner+1) mod FUNCCOUNT, wrap at FUNCCOUNT-1 -> 0, with last_winner = FUNCCOUNT-1 after reset (index 0 has first priority).
REQ-017 In GRANT, the module SHALL hold the grant while req[winner] = 1; requests from other functions SHALL NOT preempt it.
REQ-018 When req[winner] falls while the winner is a receive index (< RXCOUNT), the module SHALL, on the next edge, either grant the next round-robin requester directly (GRANT->GRANT) or go to IDLE if none.
REQ-019 When req[winner] falls while the winner is a transmit index (>= RXCOUNT), the module SHALL enter TURNAROUND with grant = 0 and func_select = 0 for exactly TURNAROUND cycles, then re-arbitrate as from IDLE.
REQ-020 Requests arriving during TURNAROUND SHALL be queued by their level only; nothing is granted before TURNAROUND ends.
REQ-021 A requester re-asserting req immediately after release SHALL win again only if no other req bit is set.
REQ-022 Deasserting req for a non-granted index SHALL have no effect.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 While rst_n = 0 at a clock edge, the module SHALL set state = IDLE, grant = 0, func_select = 0, busy = 0, last_winner = FUNCCOUNT-1, and clear the turnaround and timeout counters.
REQ-025 Reset asserted mid-GRANT or mid-TURNAROUND SHALL abort it immediately at that edge with no turnaround.
REQ-026 Arbitration SHALL resume on the first edge with rst_n = 1.

Configuration
REQ-027 With macro IO_MUX_ARBITER_TIMEOUT_EN defined, a grant held TIMEOUT consecutive cycles SHALL be revoked on the next edge even if req[winner] = 1, taking the normal path (TURNAROUND if transmit, else re-arbitrate) with the revoked index becoming last_winner.
REQ-028 Without IO_MUX_ARBITER_TIMEOUT_EN, grants SHALL be unbounded and no timeout counter is synthesized.

Verification
REQ-029 Reset, then req = 4'b0001 at cycle 0 SHALL give grant = 0001 and func_select = 0 at cycle 1; req = 0 at cycle 5 SHALL give IDLE and busy = 0 at cycle 6.
REQ-030 With req = 4'b1100 held (TX=2, RX=2), grant SHALL be 0100 (func_select = 2); dropping req[2] SHALL give grant = 0 for 2 cycles, then 1000 (func_select = 3).
REQ-031 With req = 4'b0011 and each bit released after its grant, grants SHALL alternate 0001, 0010, 0001 with no idle cycle between receive grants.
REQ-032 Asserting rst_n = 0 for one cycle during TURNAROUND SHALL give grant = 0 and busy = 0 at the next edge, and with req = 4'b0010 held SHALL give grant = 0010 one cycle after reset release.
REQ-033 With IO_MUX_ARBITER_TIMEOUT_EN, TIMEOUT = 4 and req = 4'b1001 held, the module SHALL grant 0001 for 4 cycles, then 1000 for 4 cycles, then 0 for 2 turnaround cycles, then 0001.
REQ-034 Without IO_MUX_ARBITER_TIMEOUT_EN, req = 4'b0001 held 100 cycles SHALL keep grant = 0001 throughout.
